dmem_sram_bridge: RTL and testbench
===================================

Name: dmem_sram_bridge

Overview:
- Data-side bridge between the core's memory stage and the SRAM-like data bus. It sits directly downstream of the core's aluoutM, writedataM, readEnM and writeEnM outputs.
- It converts one single-cycle M-stage access into an address-phase/data-phase handshake.
- It stalls the pipeline until the access completes, then holds read data until the frozen pipeline advances.
- At most one transaction is outstanding at any time.

Parameters:
- ADDR_W, 32, width of the CPU and bus address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_W  M-stage byte address (aluoutM).
- cpu_wdata  in  32  M-stage store data, already byte-lane shifted.
- cpu_ren  in  4  read byte mask; nonzero means load.
- cpu_wen  in  4  write byte mask; nonzero means store, and it wins if both masks are nonzero.
- cpu_flush  in  1  M-stage instruction cancelled (exception).
- cpu_hold  in  1  pipeline frozen by a stall source other than this block.
- cpu_rdata  out  32  load data, valid in DONE.
- cpu_stall  out  1  freeze the pipeline.
- cpu_adel  out  1  load address error pulse.
- cpu_ades  out  1  store address error pulse.
- bus_req  out  1  address-phase request.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_addr  out  ADDR_W  request address.
- bus_wdata  out  32  write data.
- bus_wstrb  out  4  write byte strobes (copy of cpu_wen).
- bus_addr_ok  in  1  address phase accepted this cycle.
- bus_data_ok  in  1  data phase complete this cycle.
- bus_rdata  in  32  read data, valid with bus_data_ok.

Behaviour:
- Reset:
  - Synchronous, active-high. State goes to IDLE.
  - bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb, cpu_rdata and the cancel flag all clear to 0.
  - Reset mid-transaction abandons it, and bus_req is low in the cycle after the reset edge.
- Access request: access = (cpu_ren != 0) || (cpu_wen != 0).
- Size decode from the active mask:
  - 1111 gives 2; 0011 or 1100 gives 1; one-hot gives 0.
  - Any other nonzero mask gives 2.
- States:
  - IDLE:
    - If access is high and cpu_flush is low: register addr, wdata, wr, size and wstrb, then go to ADDR.
    - cpu_stall = access & ~cpu_flush, combinational, so the request cycle itself is stalled.
    - Otherwise stay in IDLE with cpu_stall = 0.
  - ADDR:
    - bus_req = 1; the bus fields are the registered values and stay stable.
    - On bus_addr_ok go to DATA. The request is never withdrawn before addr_ok.
    - cpu_stall = 1.
  - DATA:
    - bus_req = 0 and cpu_stall = 1.
    - On bus_data_ok: for loads, cpu_rdata is loaded from bus_rdata. Then go to DONE, or to IDLE if cancelled.
    - bus_data_ok in the same cycle as bus_addr_ok (in ADDR) is ignored.
  - DONE:
    - cpu_stall = 0; cpu_rdata holds its value.
    - Stay while cpu_hold = 1, which guarantees no re-issue of the same instruction. Go to IDLE when cpu_hold = 0.
- Flush during ADDR or DATA:
  - Set the cancel flag; the bus transaction still completes.
  - cpu_rdata is not updated. At data_ok go to IDLE and clear the flag.
  - cpu_stall stays 1 until then.
- Latency with zero-wait bus (addr_ok in the first ADDR cycle, data_ok in the first DATA cycle): the request is issued in IDLE at cycle 0, with ADDR at cycle 1, DATA at cycle 2 and DONE at cycle 3. That is 3 stalled cycles. Each bus wait cycle adds one.
- No address arithmetic: bus_addr = cpu_addr unchanged.

Optional Feature:
DMEM_BRIDGE_ALIGN_CHK_EN
- When defined, IDLE checks alignment: size 2 with addr[1:0] != 0, or size 1 with addr[0] != 0, is misaligned.
- On a misaligned access:
  - No bus transaction is issued, the state stays IDLE and cpu_stall = 0.
  - cpu_adel (load) or cpu_ades (store) is 1 combinationally in that cycle.
- When not defined, cpu_adel and cpu_ades are tied 0 and every access is issued.

Test Plan:
- Load word, zero-wait bus:
  - Stimulus: cpu_ren = 1111, addr = 0x0000_0010, bus_rdata = 0xDEADBEEF.
  - Required: bus_req high in cycle 1 only with bus_size = 2; cpu_stall high in cycles 0–2; DONE in cycle 3 with cpu_rdata = 0xDEADBEEF and stall low.
- Store half with 2 addr wait and 3 data wait cycles:
  - Stimulus: cpu_wen = 1100, addr = 0x22, wdata = 0xABCD0000.
  - Required: bus_wr = 1, bus_size = 1, bus_wstrb = 1100, all stable for 3 bus_req cycles; cpu_stall high for 1 + 3 + 4 = 8 cycles.
- cpu_hold = 1 for 4 cycles after the load completes:
  - Required: the block stays in DONE, cpu_rdata stays held, and exactly one bus_req pulse occurs.
- cpu_flush asserted in the first DATA cycle of a load:
  - Required: the transaction finishes, cpu_rdata keeps its old value, the block goes to IDLE with no DONE, and stall drops the cycle after data_ok.
- rst asserted while in ADDR:
  - Required: next cycle bus_req = 0, cpu_stall = 0 and cpu_rdata = 0.
- With DMEM_BRIDGE_ALIGN_CHK_EN, load word at addr = 0x13:
  - Required: cpu_adel = 1 for that cycle, no bus_req and no stall.
  - Without the macro, the same stimulus issues bus_addr = 0x13.

Source files
------------

// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge: turns a single-cycle M-stage load/store into an
// address-phase/data-phase SRAM-like bus handshake, stalling the pipeline
// until the access completes and holding load data until the pipeline moves.
// Optional build macro: DMEM_BRIDGE_ALIGN_CHK_EN (alignment check in IDLE,
// raising cpu_adel/cpu_ades instead of issuing a misaligned access).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction outstanding; issue on a non-flushed access
// ADDR  | bus_req held high with stable fields until bus_addr_ok
// DATA  | waiting for bus_data_ok; load data captured unless cancelled
// DONE  | access finished, stall released; wait for cpu_hold to drop
module dmem_sram_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_ren,
  input  logic [3:0]        cpu_wen,
  input  logic              cpu_flush,
  input  logic              cpu_hold,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_adel,
  output logic              cpu_ades,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t     state;
  logic       cancelFlag;
  logic       accessReq;
  logic       wrSel;
  logic [3:0] activeMask;
  logic [1:0] sizeSel;
  logic       misalign;
  logic       issue;

  // Decode the M-stage request: store mask wins when both masks are set.
  always_comb begin
    accessReq  = (cpu_ren != 4'b0000) || (cpu_wen != 4'b0000);
    wrSel      = (cpu_wen != 4'b0000);
    activeMask = wrSel ? cpu_wen : cpu_ren;
    case (activeMask)
      4'b1111:                            sizeSel = 2'd2;
      4'b0011, 4'b1100:                   sizeSel = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sizeSel = 2'd0;
      default:                            sizeSel = 2'd2;
    endcase
  end

`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
  // Misaligned word/half accesses are rejected in IDLE with an error pulse.
  always_comb begin
    misalign = ((sizeSel == 2'd2) && (cpu_addr[1:0] != 2'b00)) ||
               ((sizeSel == 2'd1) && cpu_addr[0]);
    cpu_adel = (state == IDLE) && accessReq && !cpu_flush && misalign && !wrSel;
    cpu_ades = (state == IDLE) && accessReq && !cpu_flush && misalign && wrSel;
  end
`else
  // Without the alignment check every access goes out to the bus.
  always_comb begin
    misalign = 1'b0;
    cpu_adel = 1'b0;
    cpu_ades = 1'b0;
  end
`endif

  // Stall is combinational so the request cycle itself is already frozen.
  always_comb begin
    issue = (state == IDLE) && accessReq && !cpu_flush && !misalign;
    case (state)
      IDLE:       cpu_stall = issue;
      ADDR, DATA: cpu_stall = 1'b1;
      default:    cpu_stall = 1'b0;
    endcase
  end

  // Transaction FSM with registered bus fields and load-data holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cancelFlag <= 1'b0;
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_size   <= 2'd0;
      bus_addr   <= '0;
      bus_wdata  <= 32'h0;
      bus_wstrb  <= 4'b0000;
      cpu_rdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            bus_addr  <= cpu_addr;
            bus_wdata <= cpu_wdata;
            bus_wr    <= wrSel;
            bus_size  <= sizeSel;
            bus_wstrb <= cpu_wen;
            bus_req   <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (cpu_flush) cancelFlag <= 1'b1;
          // data_ok arriving alongside addr_ok is not for this phase
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cpu_flush) cancelFlag <= 1'b1;
          if (bus_data_ok) begin
            if (cancelFlag || cpu_flush) begin
              cancelFlag <= 1'b0;
              state      <= IDLE;
            end else begin
              if (!bus_wr) cpu_rdata <= bus_rdata;
              state <= DONE;
            end
          end
        end
        DONE: begin
          // staying here while held keeps the same instruction from re-issuing
          if (!cpu_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: table-driven transactions,
// hand-written hold/flush/reset/alignment sequences and randomized
// transactions judged against a transaction-level expectation.
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_ren;
  logic [3:0]  cpu_wen;
  logic        cpu_flush;
  logic        cpu_hold;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_adel;
  logic        cpu_ades;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int nChecks = 0;
  int nErrors = 0;
  logic [31:0] modelRdata;

  always #5 clk = ~clk;

  dmem_sram_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
    .cpu_flush(cpu_flush), .cpu_hold(cpu_hold), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_adel(cpu_adel), .cpu_ades(cpu_ades),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [3:0]  ren;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          aw;
    int          dw;
    logic        expWr;
    logic [1:0]  expSize;
    logic [3:0]  expStrb;
    int          expStall;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Size from the active byte mask: full word, aligned half pair, single byte, else word.
  function automatic logic [1:0] refSize(input logic [3:0] m);
    if (m == 4'hF) return 2'd2;
    if (m == 4'h3 || m == 4'hC) return 2'd1;
    if ($countones(m) == 1) return 2'd0;
    return 2'd2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays CPU and bus for one access. aw/dw are the bus wait cycles in each
  // phase; flushAt (<0 = none) is the cycle index at which cpu_flush pulses.
  task automatic runTxn(input logic [3:0] ren, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int aw, input int dw, input logic [31:0] rd,
                        input int flushAt, input int holdN,
                        input logic expWr, input logic [1:0] expSize,
                        input logic [3:0] expStrb, input int expStall, input string tag);
    int cyc, stallCnt, reqCnt, firstReq, dataCnt, phase;
    bit fieldsOk, done, holdOk;
    logic [31:0] expRd;
    expRd = (expWr || flushAt >= 0) ? modelRdata : rd;
    cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    cpu_flush = 1'b0; cpu_hold = 1'b0;
    cyc = 0; stallCnt = 0; reqCnt = 0; firstReq = -1; dataCnt = 0; phase = 0;
    fieldsOk = 1'b1; done = 1'b0;
    while (!done && cyc < 60) begin
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
      if (bus_req) begin
        reqCnt++;
        if (firstReq < 0) firstReq = cyc;
        if (bus_wr !== expWr || bus_size !== expSize || bus_addr !== addr ||
            bus_wstrb !== expStrb || bus_wdata !== wdata) fieldsOk = 1'b0;
      end
      if (phase == 0) begin
        if (bus_req && reqCnt == aw + 1) begin
          bus_addr_ok = 1'b1;
          bus_data_ok = 1'($urandom_range(0, 1));
          phase = 1;
        end
      end else if (phase == 1) begin
        if (dataCnt == dw) begin
          bus_data_ok = 1'b1;
          bus_rdata = rd;
          phase = 2;
        end
        dataCnt++;
      end
      if (cyc == flushAt) cpu_flush = 1'b1;
      else if (flushAt >= 0 && cyc == flushAt + 1) begin
        cpu_flush = 1'b0; cpu_ren = 4'b0; cpu_wen = 4'b0;
      end
      #1;
      if (cpu_stall) stallCnt++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; cpu_flush = 1'b0;
    if (flushAt >= 0) begin cpu_ren = 4'b0; cpu_wen = 4'b0; end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_stall_cycles"}, stallCnt, expStall);
    chk({tag, "_req_cycles"}, reqCnt, aw + 1);
    chk({tag, "_first_req_cycle"}, firstReq, 1);
    chk({tag, "_bus_fields"}, {31'd0, fieldsOk}, 32'd1);
    chk({tag, "_rdata"}, cpu_rdata, expRd);
    modelRdata = expRd;
    holdOk = 1'b1;
    for (int i = 0; i < holdN; i++) begin
      cpu_hold = 1'b1;
      @(posedge clk); #2;
      if (bus_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== expRd) holdOk = 1'b0;
    end
    if (holdN > 0) chk({tag, "_hold"}, {31'd0, holdOk}, 32'd1);
    cpu_hold = 1'b0;
    tick();
    cpu_ren = 4'b0; cpu_wen = 4'b0;
    #1;
  endtask

  initial begin
    logic [3:0]  ren, wen, m;
    logic [31:0] a;
    logic [1:0]  sz;
    int aw, dw, fa;

    vecs[0] = '{4'hF, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 1'b0, 2'd2, 4'h0, 3};
    vecs[1] = '{4'h0, 4'hC, 32'h0000_0022, 32'hABCD_0000, 32'h0,         2, 3, 1'b1, 2'd1, 4'hC, 8};
    vecs[2] = '{4'h2, 4'h0, 32'h0000_0041, 32'h0,         32'h1234_5678, 1, 0, 1'b0, 2'd0, 4'h0, 4};
    vecs[3] = '{4'h5, 4'h0, 32'h0000_0080, 32'h0,         32'hCAFE_F00D, 0, 2, 1'b0, 2'd2, 4'h0, 5};
    vecs[4] = '{4'hF, 4'h3, 32'h0000_0104, 32'h0000_5A5A, 32'h0,         1, 1, 1'b1, 2'd1, 4'h3, 5};

    rst = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_ren = 4'h0; cpu_wen = 4'h0;
    cpu_flush = 1'b0; cpu_hold = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_bus_req", {31'd0, bus_req}, 32'd0);
    chk("reset_bus_fields", {bus_wr, bus_size, bus_wstrb}, 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    chk("reset_bus_wdata", bus_wdata, 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    chk("reset_stall", {31'd0, cpu_stall}, 32'd0);
    modelRdata = 32'h0;

    for (int i = 0; i < 5; i++)
      runTxn(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].aw, vecs[i].dw,
             vecs[i].rd, -1, 0, vecs[i].expWr, vecs[i].expSize, vecs[i].expStrb,
             vecs[i].expStall, $sformatf("vec%0d", i));

    // load completes, then the pipeline stays frozen for 4 cycles
    runTxn(4'hF, 4'h0, 32'h30, 32'h0, 0, 0, 32'h1122_3344, -1, 4,
           1'b0, 2'd2, 4'h0, 3, "hold");

    // flush in the first DATA cycle of a load
    runTxn(4'hF, 4'h0, 32'h60, 32'h0, 0, 1, 32'h9999_9999, 2, 0,
           1'b0, 2'd2, 4'h0, 4, "flush");

    // reset while in ADDR
    cpu_ren = 4'hF; cpu_addr = 32'h50;
    tick();
    chk("rst_pre_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1; cpu_ren = 4'h0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    tick();
    chk("rst_req_after", {31'd0, bus_req}, 32'd0);
    modelRdata = 32'h0;

`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
    cpu_ren = 4'hF; cpu_addr = 32'h13;
    #1;
    chk("align_adel", {31'd0, cpu_adel}, 32'd1);
    chk("align_ades", {31'd0, cpu_ades}, 32'd0);
    chk("align_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    chk("align_no_req", {31'd0, bus_req}, 32'd0);
    cpu_ren = 4'h0; cpu_wen = 4'h3; cpu_addr = 32'h21;
    #1;
    chk("align_ades_store", {31'd0, cpu_ades}, 32'd1);
    chk("align_adel_store", {31'd0, cpu_adel}, 32'd0);
    tick();
    chk("align_no_req_store", {31'd0, bus_req}, 32'd0);
    cpu_wen = 4'h0;
    tick();
`else
    cpu_ren = 4'hF; cpu_addr = 32'h13;
    #1;
    chk("noalign_adel", {31'd0, cpu_adel}, 32'd0);
    runTxn(4'hF, 4'h0, 32'h13, 32'h0, 0, 0, 32'h0BAD_A11E, -1, 0,
           1'b0, 2'd2, 4'h0, 3, "noalign");
`endif

    for (int t = 0; t < 40; t++) begin
      m = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0: begin ren = m; wen = 4'h0; end
        1: begin ren = 4'h0; wen = m; end
        default: begin ren = 4'($urandom_range(1, 15)); wen = m; end
      endcase
      sz = refSize(m);
      a = $urandom & 32'h0000_FFFF;
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
      if (sz == 2'd2) a[1:0] = 2'b00;
      else if (sz == 2'd1) a[0] = 1'b0;
`endif
      aw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 + aw + dw)) : -1;
      runTxn(ren, wen, a, $urandom, aw, dw, $urandom, fa, $urandom_range(0, 3),
             (wen != 4'h0), sz, wen, 3 + aw + dw, $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
